// File: rtl/stage4_mem_stage.sv
// Memory stage: drives the data bus, aligns/extends loads, produces writeback and
// fetch-redirect values, and stalls upstream during bus waits and fence.i flushes.
module stage4_mem_stage #(
   parameter int unsigned RESET_PC_DONTCARE = 0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic        ex_ren,
   input  logic        ex_wen,
   input  logic [2:0]  ex_funct3,
   input  logic        ex_jump,
   input  logic        ex_brj_taken,
   input  logic [31:0] ex_brj_addr,
   input  logic        ex_ifence,
   output logic [31:0] dmem_addr,
   output logic        dmem_ren,
   output logic        dmem_wen,
   output logic [3:0]  dmem_byte_en,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_busy,
   output logic        dcache_flush,
   input  logic        dcache_flush_done,
   output logic        mem_stall,
   output logic        redirect,
   output logic [31:0] brj_addr,
   output logic [31:0] pc4,
   output logic        reg_write,
   output logic [4:0]  rd_m,
   output logic [31:0] reg_wdata,
   output logic        misaligned,
   output logic        mem_retire
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] ACCESS     = 2'd1;
   localparam logic [1:0] FLUSH      = 2'd2;
   localparam logic [1:0] FLUSH_WAIT = 2'd3;

   // Reserved parameter: elaborates to nothing.
   if (RESET_PC_DONTCARE != 0) begin : g_reserved
   end

   logic [1:0]  state, state_nxt;
   logic        fence_done, fence_done_nxt;
   logic        mem_op, misaligned_c, access_req, in_mem_phase;
   logic        fence_redirect, stall_c;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   always_comb begin
      mem_op = ex_valid & (ex_ren | ex_wen);
      case (ex_funct3[1:0])
         2'b01:   misaligned_c = mem_op & ex_alu_result[0];
         2'b10:   misaligned_c = mem_op & (|ex_alu_result[1:0]);
         default: misaligned_c = 1'b0;
      endcase
      access_req     = mem_op & ~misaligned_c;
      in_mem_phase   = (state == IDLE) | (state == ACCESS);
      // fence_done marks the single redirect cycle after the flush has finished
      fence_redirect = (state == IDLE) & fence_done & ex_valid;
   end

   always_comb begin
      stall_c        = 1'b0;
      state_nxt      = state;
      fence_done_nxt = fence_done;
      case (state)
         IDLE: begin
            if (fence_done) begin
               fence_done_nxt = 1'b0;
            end else if (ex_valid & ex_ifence) begin
               stall_c   = 1'b1;
               state_nxt = FLUSH;
            end else if (access_req & dmem_busy) begin
               stall_c   = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            stall_c = access_req & dmem_busy;
            if (!stall_c) state_nxt = IDLE;
         end
         FLUSH: begin
            stall_c   = 1'b1;
            state_nxt = FLUSH_WAIT;
         end
         default: begin
            stall_c = 1'b1;
            if (dcache_flush_done) begin
               state_nxt      = IDLE;
               fence_done_nxt = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         fence_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         fence_done <= fence_done_nxt;
      end
   end

   always_comb begin
      case (ex_funct3[1:0])
         2'b00: begin
            dmem_byte_en = 4'b0001 << ex_alu_result[1:0];
            dmem_wdata   = {4{ex_store_data[7:0]}};
         end
         2'b01: begin
            dmem_byte_en = ex_alu_result[1] ? 4'b1100 : 4'b0011;
            dmem_wdata   = {2{ex_store_data[15:0]}};
         end
         default: begin
            dmem_byte_en = 4'b1111;
            dmem_wdata   = ex_store_data;
         end
      endcase
   end

   always_comb begin
      case (ex_alu_result[1:0])
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = ex_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (ex_funct3)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_data = {24'd0, ld_byte};
         3'b101:  load_data = {16'd0, ld_half};
         default: load_data = dmem_rdata;
      endcase
   end

   assign dmem_addr    = {ex_alu_result[31:2], 2'b00};
   assign dmem_ren     = nRST & in_mem_phase & access_req & ex_ren;
   assign dmem_wen     = nRST & in_mem_phase & access_req & ex_wen;
   assign dcache_flush = nRST & (state == FLUSH);
   assign mem_stall    = nRST & stall_c;
   assign pc4          = ex_pc + 32'd4;
   assign redirect     = nRST & (fence_redirect | (ex_valid & ex_brj_taken));
   assign brj_addr     = fence_redirect ? pc4 : ex_brj_addr;
   assign rd_m         = ex_rd;
   assign reg_wdata    = ex_ren ? load_data : (ex_jump ? pc4 : ex_alu_result);
   assign reg_write    = nRST & ex_valid & ex_reg_write & ~misaligned_c & ~stall_c;
   assign misaligned   = nRST & misaligned_c;
   assign mem_retire   = nRST & ex_valid & in_mem_phase & ~stall_c;

endmodule

// File: tb/tb_stage4_mem_stage.sv
// Scoreboard bench for stage4_mem_stage: expectations queued at issue, checked on retire.
module tb_stage4_mem_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ex_valid, ex_reg_write, ex_ren, ex_wen, ex_jump, ex_brj_taken, ex_ifence;
   logic [31:0] ex_pc, ex_alu_result, ex_store_data, ex_brj_addr;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, brj_addr, pc4, reg_wdata;
   logic        dmem_ren, dmem_wen, dmem_busy, dcache_flush, dcache_flush_done;
   logic        mem_stall, redirect, reg_write, misaligned, mem_retire;
   logic [3:0]  dmem_byte_en;
   logic [4:0]  rd_m;

   typedef struct {
      logic        rw;
      logic        mis;
      logic        chk;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int pass_cnt = 0;
   int total_cnt = 0;
   int retire_cnt = 0;

   stage4_mem_stage #(.RESET_PC_DONTCARE(0)) dut (
      .CLK(CLK), .nRST(nRST),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_ren(ex_ren), .ex_wen(ex_wen), .ex_funct3(ex_funct3), .ex_jump(ex_jump),
      .ex_brj_taken(ex_brj_taken), .ex_brj_addr(ex_brj_addr), .ex_ifence(ex_ifence),
      .dmem_addr(dmem_addr), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
      .dmem_byte_en(dmem_byte_en), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_busy(dmem_busy), .dcache_flush(dcache_flush), .dcache_flush_done(dcache_flush_done),
      .mem_stall(mem_stall), .redirect(redirect), .brj_addr(brj_addr), .pc4(pc4),
      .reg_write(reg_write), .rd_m(rd_m), .reg_wdata(reg_wdata),
      .misaligned(misaligned), .mem_retire(mem_retire)
   );

   always #5 CLK = ~CLK;

   // Retire monitor: every completion must match the oldest queued expectation.
   always @(negedge CLK) begin : mon
      exp_t e;
      if (mem_retire) begin
         retire_cnt++;
         total_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL retire_unexpected: got mem_retire=1, expected no retire (queue empty)");
         end else begin
            e = sb.pop_front();
            if ({reg_write, misaligned, rd_m} !== {e.rw, e.mis, e.rd} || (e.chk && reg_wdata !== e.wdata))
               $display("FAIL retire_result: got rw=%b mis=%b rd=%0d wdata=%h, expected rw=%b mis=%b rd=%0d wdata=%h",
                        reg_write, misaligned, rd_m, reg_wdata, e.rw, e.mis, e.rd, e.wdata);
            else
               pass_cnt++;
         end
      end
   end

   always @(negedge CLK) begin
      if (nRST && ex_valid) begin
         assert (!(ex_ren && ex_wen)) else $error("illegal ex op: load and store together");
         assert (!(ex_ifence && (ex_ren || ex_wen))) else $error("illegal ex op: fence.i with memory op");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "timeout");
   end

   task automatic idle_ex();
      ex_valid = 0; ex_pc = '0; ex_rd = '0; ex_reg_write = 0; ex_alu_result = '0;
      ex_store_data = '0; ex_ren = 0; ex_wen = 0; ex_funct3 = '0; ex_jump = 0;
      ex_brj_taken = 0; ex_brj_addr = '0; ex_ifence = 0;
   endtask

   task automatic set_ex(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [2:0] f3, input logic ren, input logic wen, input logic rw,
                         input logic [4:0] rd, input logic jump, input logic taken,
                         input logic [31:0] baddr, input logic ifence);
      ex_valid = 1; ex_pc = pc; ex_alu_result = alu; ex_store_data = sd; ex_funct3 = f3;
      ex_ren = ren; ex_wen = wen; ex_reg_write = rw; ex_rd = rd; ex_jump = jump;
      ex_brj_taken = taken; ex_brj_addr = baddr; ex_ifence = ifence;
   endtask

   task automatic test_reset();
      nRST = 0;
      set_ex(32'h10, 32'h100, '0, 3'b010, 1, 0, 1, 5'd1, 0, 1, 32'h80, 0);
      dmem_busy = 1; dmem_rdata = '0; dcache_flush_done = 0;
      #12;
      total_cnt++;
      if ({dmem_ren, dmem_wen, dcache_flush, redirect, reg_write, misaligned, mem_retire, mem_stall} !== 8'h00)
         $display("FAIL reset_outputs: got %b, expected 00000000",
                  {dmem_ren, dmem_wen, dcache_flush, redirect, reg_write, misaligned, mem_retire, mem_stall});
      else pass_cnt++;
      idle_ex(); dmem_busy = 0;
      @(posedge CLK); #1 nRST = 1;
   endtask

   task automatic test_lw();
      int r0;
      r0 = retire_cnt;
      @(posedge CLK); #1;
      set_ex(32'h10, 32'h100, '0, 3'b010, 1, 0, 1, 5'd5, 0, 0, '0, 0);
      dmem_rdata = 32'h8899AABB; dmem_busy = 0;
      sb.push_back('{rw: 1'b1, mis: 1'b0, chk: 1'b1, wdata: 32'h8899AABB, rd: 5'd5});
      @(negedge CLK);
      total_cnt++;
      if ({mem_stall, dmem_ren, dmem_wen, reg_write} !== 4'b0101)
         $display("FAIL lw_ctrl: got stall/ren/wen/rw=%b, expected 0101", {mem_stall, dmem_ren, dmem_wen, reg_write});
      else pass_cnt++;
      total_cnt++;
      if (dmem_addr !== 32'h100) $display("FAIL lw_addr: got %h, expected 00000100", dmem_addr);
      else pass_cnt++;
      @(posedge CLK); #1 idle_ex();
      total_cnt++;
      if (retire_cnt !== r0 + 1) $display("FAIL lw_retire_count: got %0d, expected %0d", retire_cnt - r0, 1);
      else pass_cnt++;
   endtask

   task automatic test_loads();
      logic [31:0] addr_t[5]  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
      logic [31:0] rdata_t[5] = '{32'h80000000, 32'h80000000, 32'hBEEF0000, 32'h80000000, 32'h1234567F};
      logic [2:0]  f3_t[5]    = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
      logic [31:0] exp_t_[5]  = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFF8000, 32'h0000007F};
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         set_ex(32'h20, addr_t[i], '0, f3_t[i], 1, 0, 1, 5'd9, 0, 0, '0, 0);
         dmem_rdata = rdata_t[i]; dmem_busy = 0;
         sb.push_back('{rw: 1'b1, mis: 1'b0, chk: 1'b1, wdata: exp_t_[i], rd: 5'd9});
         @(negedge CLK);
         total_cnt++;
         if (reg_wdata !== exp_t_[i]) $display("FAIL load_ext_%0d: got %h, expected %h", i, reg_wdata, exp_t_[i]);
         else pass_cnt++;
      end
      @(posedge CLK); #1 idle_ex();
   endtask

   task automatic test_store_busy();
      int r0, stall_cycles;
      logic stable_ok;
      r0 = retire_cnt; stall_cycles = 0; stable_ok = 1;
      @(posedge CLK); #1;
      set_ex(32'h30, 32'h101, 32'h12345678, 3'b000, 0, 1, 0, 5'd0, 0, 0, '0, 0);
      dmem_busy = 1;
      sb.push_back('{rw: 1'b0, mis: 1'b0, chk: 1'b1, wdata: 32'h101, rd: 5'd0});
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (mem_stall) stall_cycles++;
         if (mem_retire) stable_ok = 0;
         if (dmem_wen !== 1'b1 || dmem_ren !== 1'b0 || dmem_byte_en !== 4'b0010 ||
             dmem_wdata !== 32'h78787878 || dmem_addr !== 32'h100) stable_ok = 0;
         @(posedge CLK); #1;
         if (i == 2) dmem_busy = 0;
      end
      @(negedge CLK);
      total_cnt++;
      if ({mem_stall, mem_retire, dmem_wen} !== 3'b011)
         $display("FAIL sb_complete: got stall/retire/wen=%b, expected 011", {mem_stall, mem_retire, dmem_wen});
      else pass_cnt++;
      @(posedge CLK); #1 idle_ex();
      total_cnt++;
      if (stall_cycles !== 3) $display("FAIL sb_stall_cycles: got %0d, expected 3", stall_cycles);
      else pass_cnt++;
      total_cnt++;
      if (stable_ok !== 1'b1) $display("FAIL sb_request_stable: got %b, expected 1", stable_ok);
      else pass_cnt++;
      total_cnt++;
      if (retire_cnt !== r0 + 1) $display("FAIL sb_retire_count: got %0d, expected 1", retire_cnt - r0);
      else pass_cnt++;
   endtask

   task automatic test_misaligned();
      @(posedge CLK); #1;
      set_ex(32'h40, 32'h101, '0, 3'b001, 1, 0, 1, 5'd7, 0, 0, '0, 0);
      dmem_busy = 1;
      sb.push_back('{rw: 1'b0, mis: 1'b1, chk: 1'b0, wdata: '0, rd: 5'd7});
      @(negedge CLK);
      total_cnt++;
      if ({misaligned, dmem_ren, reg_write, mem_stall} !== 4'b1000)
         $display("FAIL mis_lh: got mis/ren/rw/stall=%b, expected 1000", {misaligned, dmem_ren, reg_write, mem_stall});
      else pass_cnt++;
      @(posedge CLK); #1;
      set_ex(32'h44, 32'h102, 32'h55, 3'b010, 0, 1, 0, 5'd0, 0, 0, '0, 0);
      sb.push_back('{rw: 1'b0, mis: 1'b1, chk: 1'b0, wdata: '0, rd: 5'd0});
      @(negedge CLK);
      total_cnt++;
      if ({misaligned, dmem_wen, mem_stall} !== 3'b100)
         $display("FAIL mis_sw: got mis/wen/stall=%b, expected 100", {misaligned, dmem_wen, mem_stall});
      else pass_cnt++;
      @(posedge CLK); #1 idle_ex(); dmem_busy = 0;
   endtask

   task automatic test_fence(input logic [31:0] pc, input logic [7:0] done_mask, input int exp_cyc);
      int r0, flush_cnt, flush_cyc, red_cyc;
      logic stall_ok;
      logic [31:0] red_addr;
      r0 = retire_cnt; flush_cnt = 0; flush_cyc = -1; red_cyc = -1; stall_ok = 1; red_addr = '0;
      @(posedge CLK); #1;
      set_ex(pc, '0, '0, 3'b000, 0, 0, 0, 5'd0, 0, 0, 32'hDEAD0000, 1);
      dcache_flush_done = done_mask[0];
      sb.push_back('{rw: 1'b0, mis: 1'b0, chk: 1'b0, wdata: '0, rd: 5'd0});
      for (int c = 0; c < 20 && red_cyc < 0; c++) begin
         @(negedge CLK);
         if (dcache_flush) begin flush_cnt++; flush_cyc = c; end
         if (redirect) begin
            red_cyc = c; red_addr = brj_addr;
            if (mem_stall) stall_ok = 0;
         end else if (!mem_stall) stall_ok = 0;
         @(posedge CLK); #1;
         dcache_flush_done = (c + 1 < 8) ? done_mask[c + 1] : 1'b0;
      end
      idle_ex(); dcache_flush_done = 0;
      total_cnt++;
      if (red_cyc !== exp_cyc) $display("FAIL fence_latency: got redirect at cycle %0d, expected %0d", red_cyc, exp_cyc);
      else pass_cnt++;
      total_cnt++;
      if (flush_cnt !== 1 || flush_cyc !== 1)
         $display("FAIL fence_flush_pulse: got %0d pulses at cycle %0d, expected 1 at cycle 1", flush_cnt, flush_cyc);
      else pass_cnt++;
      total_cnt++;
      if (red_addr !== pc + 32'd4) $display("FAIL fence_brj_addr: got %h, expected %h", red_addr, pc + 32'd4);
      else pass_cnt++;
      total_cnt++;
      if (stall_ok !== 1'b1) $display("FAIL fence_stall: got stall pattern ok=%b, expected 1", stall_ok);
      else pass_cnt++;
      total_cnt++;
      if (retire_cnt !== r0 + 1) $display("FAIL fence_retire_count: got %0d, expected 1", retire_cnt - r0);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int r0;
      r0 = retire_cnt;
      @(posedge CLK); #1;
      set_ex(32'h50, 32'h104, '0, 3'b010, 1, 0, 1, 5'd1, 0, 0, '0, 0);
      dmem_rdata = 32'hCAFEF00D; dmem_busy = 0;
      sb.push_back('{rw: 1'b1, mis: 1'b0, chk: 1'b1, wdata: 32'hCAFEF00D, rd: 5'd1});
      @(posedge CLK); #1;
      set_ex(32'h54, 32'h106, 32'hABCD1234, 3'b001, 0, 1, 0, 5'd2, 0, 0, '0, 0);
      sb.push_back('{rw: 1'b0, mis: 1'b0, chk: 1'b1, wdata: 32'h106, rd: 5'd2});
      @(negedge CLK);
      total_cnt++;
      if ({dmem_byte_en, dmem_wdata, dmem_addr} !== {4'b1100, 32'h12341234, 32'h104})
         $display("FAIL sh_lanes: got be=%b wdata=%h addr=%h, expected be=1100 wdata=12341234 addr=00000104",
                  dmem_byte_en, dmem_wdata, dmem_addr);
      else pass_cnt++;
      @(posedge CLK); #1;
      set_ex(32'h58, 32'h55, '0, 3'b000, 0, 0, 1, 5'd3, 0, 0, '0, 0);
      sb.push_back('{rw: 1'b1, mis: 1'b0, chk: 1'b1, wdata: 32'h55, rd: 5'd3});
      @(posedge CLK); #1 idle_ex();
      total_cnt++;
      if (retire_cnt !== r0 + 3) $display("FAIL b2b_retire_count: got %0d, expected 3", retire_cnt - r0);
      else pass_cnt++;
   endtask

   task automatic test_valid_low();
      @(posedge CLK); #1;
      set_ex(32'h60, 32'h100, '0, 3'b010, 1, 0, 1, 5'd4, 0, 1, 32'h900, 0);
      ex_valid = 0;
      @(negedge CLK);
      total_cnt++;
      if ({dmem_ren, dmem_wen, reg_write, redirect, mem_retire, mem_stall} !== 6'b0)
         $display("FAIL valid_low: got %b, expected 000000",
                  {dmem_ren, dmem_wen, reg_write, redirect, mem_retire, mem_stall});
      else pass_cnt++;
      @(posedge CLK); #1 idle_ex();
   endtask

   task automatic test_reset_mid_access();
      int r0;
      r0 = retire_cnt;
      @(posedge CLK); #1;
      set_ex(32'h70, 32'h100, '0, 3'b010, 1, 0, 1, 5'd6, 0, 0, '0, 0);
      dmem_busy = 1;
      sb.push_back('{rw: 1'b1, mis: 1'b0, chk: 1'b0, wdata: '0, rd: 5'd6});
      @(posedge CLK); #3 nRST = 0;
      #1;
      total_cnt++;
      if ({dmem_ren, dmem_wen, dcache_flush, redirect, reg_write, misaligned, mem_retire, mem_stall} !== 8'h00)
         $display("FAIL reset_mid_access: got %b, expected 00000000",
                  {dmem_ren, dmem_wen, dcache_flush, redirect, reg_write, misaligned, mem_retire, mem_stall});
      else pass_cnt++;
      sb.delete();
      @(posedge CLK); #1 idle_ex(); dmem_busy = 0;
      @(posedge CLK); #1 nRST = 1;
      total_cnt++;
      if (retire_cnt !== r0) $display("FAIL reset_no_retire: got %0d retires, expected 0", retire_cnt - r0);
      else pass_cnt++;
      @(posedge CLK); #1;
      set_ex(32'h40, 32'h99, '0, 3'b000, 0, 0, 1, 5'd1, 1, 1, 32'h1234, 0);
      sb.push_back('{rw: 1'b1, mis: 1'b0, chk: 1'b1, wdata: 32'h44, rd: 5'd1});
      @(negedge CLK);
      total_cnt++;
      if ({redirect, mem_stall, reg_write} !== 3'b101 || brj_addr !== 32'h1234 || reg_wdata !== 32'h44)
         $display("FAIL jal_after_reset: got red/stall/rw=%b brj=%h wdata=%h, expected 101 brj=00001234 wdata=00000044",
                  {redirect, mem_stall, reg_write}, brj_addr, reg_wdata);
      else pass_cnt++;
      @(posedge CLK); #1 idle_ex();
   endtask

   initial begin
      idle_ex();
      dmem_rdata = '0; dmem_busy = 0; dcache_flush_done = 0;
      test_reset();
      test_lw();
      test_loads();
      test_store_busy();
      test_misaligned();
      test_fence(32'h200, 8'b0010_0000, 6);
      test_fence(32'h300, 8'b0000_0100, 3);
      test_fence(32'h400, 8'b0000_1010, 4);
      test_back_to_back();
      test_valid_low();
      test_reset_mid_access();
      @(posedge CLK); #1;
      total_cnt++;
      if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/stage4_mem_stage.md
# stage4_mem_stage

Memory stage of the 4-stage pipeline: consumes the execute→mem latch, drives the data-memory bus, aligns and extends load data, and produces the writeback/forwarding values (reg_write, rd_m, reg_wdata) plus the fetch redirect (brj_addr, pc4). It owns the stall back to execute/fetch while a bus access or fence.i flush is outstanding. It sits directly downstream of execute and upstream of the register file and fetch redirect mux.

## Interface
Parameters:
- RESET_PC_DONTCARE, 0, reserved; no effect on behaviour.

Ports:
- CLK  in  1  pipeline clock; all state on rising edge.
- nRST  in  1  reset, asynchronous and active-low.
- ex_valid  in  1  latched instruction valid.
- ex_pc  in  32  PC of latched instruction.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_alu_result  in  32  ALU result / effective address.
- ex_store_data  in  32  rs2 value for stores.
- ex_ren, ex_wen  in  1 each  load / store.
- ex_funct3  in  3  load/store size and sign.
- ex_jump  in  1  JAL/JALR: rd gets pc+4.
- ex_brj_taken  in  1  taken branch/jump.
- ex_brj_addr  in  32  redirect target.
- ex_ifence  in  1  fence.i.
- dmem_addr  out  32  word-aligned address ({ex_alu_result[31:2],2'b00}).
- dmem_ren, dmem_wen  out  1 each  bus request.
- dmem_byte_en  out  4  byte lanes.
- dmem_wdata  out  32  store data, lane-replicated.
- dmem_rdata  in  32  load data, valid when dmem_busy=0.
- dmem_busy  in  1  bus not yet complete.
- dcache_flush  out  1  one-cycle flush request.
- dcache_flush_done  in  1  flush complete pulse/level.
- mem_stall  out  1  hold execute latch and fetch.
- redirect  out  1  fetch must take brj_addr.
- brj_addr, pc4  out  32 each  redirect target; ex_pc+4.
- reg_write  out  1, rd_m  out  5, reg_wdata  out  32  writeback/forwarding.
- misaligned  out  1  address-misaligned exception.
- mem_retire  out  1  instruction completed this cycle.

## Operation
- FSM states: IDLE, ACCESS, FLUSH, FLUSH_WAIT. Reset → IDLE.
- Misaligned: halfword with addr[0]=1 or word with addr[1:0]≠0 and (ex_ren|ex_wen). No bus request, misaligned=1, reg_write=0, retire=1, no stall.
- Aligned access, IDLE: dmem_ren/wen asserted combinationally from ex inputs. If dmem_busy=0 same cycle: complete, stay IDLE. Else → ACCESS, mem_stall=1.
- ACCESS: hold request; when dmem_busy=0: complete, mem_stall=0, → IDLE.
- Stores: SB byte_en=1<<addr[1:0], wdata={4{b}}; SH byte_en=addr[1]?1100:0011, wdata={2{h}}; SW 1111.
- Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass.
- reg_wdata = load ? extended data : ex_jump ? ex_pc+4 : ex_alu_result. reg_write = ex_valid & ex_reg_write & ~misaligned & ~mem_stall.
- Branch: redirect = ex_valid & ex_brj_taken, brj_addr = ex_brj_addr, same cycle.
- fence.i: IDLE → FLUSH (dcache_flush=1 one cycle) → FLUSH_WAIT until dcache_flush_done → IDLE with redirect=1, brj_addr=pc4 that cycle. mem_stall=1 in IDLE-with-fence, FLUSH, FLUSH_WAIT; 0 on the redirect cycle.
- mem_retire=1 for exactly one cycle per valid instruction, on its completion cycle.
- ex_ren&ex_wen both high, or ex_ifence with a memory op: illegal; bench asserts it never occurs.

## Timing
- Reset: state=IDLE; while nRST=0, dmem_ren/wen, dcache_flush, redirect, reg_write, misaligned, mem_retire, mem_stall forced 0. Reset mid-ACCESS/FLUSH abandons the operation immediately; no retire.
- Zero-wait access: 0 added cycles. N-cycle busy: mem_stall high N cycles, completion on first dmem_busy=0 cycle.
- Upstream holds ex_* stable while mem_stall=1; request outputs stay stable throughout.
- fence.i minimum latency: 3 cycles (FLUSH, FLUSH_WAIT seeing done, redirect) if done arrives the cycle after flush.
- dcache_flush_done in FLUSH is ignored; only sampled in FLUSH_WAIT.
- ex_valid=0: all requests, reg_write, redirect, retire = 0.

## Test plan
- LW 0x100, rdata=0x8899AABB, busy=0 → reg_wdata=0x8899AABB, reg_write=1, retire 1 cycle, no stall.
- LB addr 0x103, rdata=0x80000000 → reg_wdata=0xFFFFFF80; LBU → 0x00000080; LHU addr 0x102, rdata=0xBEEF0000 → 0x0000BEEF.
- SB addr 0x101, data 0x12345678, busy 3 cycles → byte_en=0010, wdata=0x78787878, mem_stall 3 cycles, request stable, one retire.
- LH addr 0x101 → misaligned=1, dmem_ren=0, reg_write=0, no stall.
- fence.i at pc 0x200, done 4 cycles after flush → dcache_flush one pulse, stall until done, redirect=1 with brj_addr=0x204.
- Reset asserted mid-ACCESS → all outputs 0 asynchronously, FSM IDLE, no retire; JAL pc 0x40 after reset → reg_wdata=0x44, redirect to ex_brj_addr.
